// File: rtl/memory_bank.sv
// memory_bank: DEPTH x WIDTH flip-flop word store with a 1-cycle registered
// read port and a whole-array clear sweep.
//
// Ports
//   clk      : single clock, all state changes on the rising edge
//   reset_n  : synchronous active-low reset (no asynchronous path)
//   store    : write request, mem[addr] <= data (IDLE only, addr < DEPTH)
//   load     : read request, rd_data <= mem[addr] one cycle later
//   clear    : pulse that starts a DEPTH-cycle zeroing sweep
//   addr     : word address shared by store and load
//   data     : write data
//   rd_data  : registered read data, holds its value between reads
//   rd_valid : one-cycle strobe marking a fresh rd_data
//   busy     : high while the clear sweep runs
module memory_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             store,
  input  logic             load,
  input  logic             clear,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // DEPTH widened by one bit so the range check also works when DEPTH = 2**AW.
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  state_t           state_reg, state_next;
  logic [AW-1:0]    ptr_reg, ptr_next;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [WIDTH-1:0] rd_data_reg, rd_data_next;
  logic             rd_valid_reg, rd_valid_next;

  logic             in_range;
  logic             idle;
  logic             do_write;
  logic             do_read;
  logic [WIDTH-1:0] rd_word;
  logic [DEPTH-1:0] write_sel;
  logic [DEPTH-1:0] sweep_sel;

  assign in_range = ({1'b0, addr} < DEPTH_W);
  assign idle     = (state_reg == IDLE);
  // clear in IDLE wins over a same-edge store or load.
  assign do_write = idle & ~clear & store & in_range;
  assign do_read  = idle & ~clear & load;
  assign rd_word  = in_range ? mem_reg[addr] : '0;

  // Per-word select lines: one for the write port, one for the sweep pointer.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_sel
      localparam logic [AW-1:0] IDX = AW'(gi);
      assign write_sel[gi] = do_write && (addr == IDX);
      assign sweep_sel[gi] = (state_reg == CLEAR) && (ptr_reg == IDX);
    end
  endgenerate

  // FSM state and sweep pointer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (clear) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      CLEAR: begin
        // The edge that zeroes the last word also returns to IDLE, giving
        // exactly DEPTH busy cycles.
        if (ptr_reg == LAST_PTR) begin
          state_next = IDLE;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  // Storage array: sweep and write selects are mutually exclusive by state.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!reset_n) begin
        mem_reg[i] <= '0;
      end else if (sweep_sel[i]) begin
        mem_reg[i] <= '0;
      end else if (write_sel[i]) begin
        mem_reg[i] <= data;
      end
    end
  end

  // Read port. A same-edge store always targets the load address (shared
  // addr), so a store flag alone selects the write-through path.
  always_comb begin
    rd_valid_next = do_read;
    rd_data_next  = rd_data_reg;
    if (do_read) begin
      if (!in_range) begin
        rd_data_next = '0;
      end else if (store) begin
        rd_data_next = data;
      end else begin
        rd_data_next = rd_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_data_reg  <= rd_data_next;
      rd_valid_reg <= rd_valid_next;
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign busy     = (state_reg == CLEAR);

endmodule

// File: tb/tb_memory_bank.sv
// Testbench for memory_bank: a DEPTH=8 and a DEPTH=5 instance share every
// input; a behavioural model (array + busy countdown) predicts both.
module tb_memory_bank;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       store = 1'b0;
  logic       load = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] addr = 3'd0;
  logic [7:0] data = 8'h00;

  logic [7:0] rd_data8, rd_data5;
  logic       rd_valid8, rd_valid5;
  logic       busy8, busy5;

  always #5 clk = ~clk;

  memory_bank #(.WIDTH(8), .DEPTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .store(store), .load(load), .clear(clear),
    .addr(addr), .data(data), .rd_data(rd_data8), .rd_valid(rd_valid8), .busy(busy8)
  );

  memory_bank #(.WIDTH(8), .DEPTH(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .store(store), .load(load), .clear(clear),
    .addr(addr), .data(data), .rd_data(rd_data5), .rd_valid(rd_valid5), .busy(busy5)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model, index 0 = DEPTH 8, index 1 = DEPTH 5.
  int dep [2] = '{8, 5};
  int mm  [2][8];
  int rem [2];   // busy cycles still to come; word cleared next is dep-rem
  int rdd [2];
  int rdv [2];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
  endtask

  task automatic model_edge(input logic rn, input logic st, input logic ld,
                            input logic cl, input int a, input int d);
    for (int k = 0; k < 2; k++) begin
      if (!rn) begin
        for (int i = 0; i < 8; i++) mm[k][i] = 0;
        rem[k] = 0; rdd[k] = 0; rdv[k] = 0;
      end else if (rem[k] > 0) begin
        mm[k][dep[k] - rem[k]] = 0;
        rem[k]--;
        rdv[k] = 0;
      end else if (cl) begin
        rem[k] = dep[k];
        rdv[k] = 0;
      end else begin
        rdv[k] = ld ? 1 : 0;
        if (ld) rdd[k] = (a >= dep[k]) ? 0 : (st ? d : mm[k][a]);
        if (st && a < dep[k]) mm[k][a] = d;
      end
    end
  endtask

  // One clock: drive inputs, take the edge, then compare both DUTs to the model.
  task automatic cycle(input logic rn, input logic st, input logic ld,
                       input logic cl, input int a, input int d);
    reset_n = rn; store = st; load = ld; clear = cl;
    addr = 3'(a); data = 8'(d);
    @(posedge clk);
    model_edge(rn, st, ld, cl, a, d);
    #1;
    chk("model_rd_valid8", int'(rd_valid8), rdv[0]);
    chk("model_rd_data8",  int'(rd_data8),  rdd[0]);
    chk("model_busy8",     int'(busy8),     (rem[0] > 0) ? 1 : 0);
    chk("model_rd_valid5", int'(rd_valid5), rdv[1]);
    chk("model_rd_data5",  int'(rd_data5),  rdd[1]);
    chk("model_busy5",     int'(busy5),     (rem[1] > 0) ? 1 : 0);
  endtask

  typedef struct {
    logic       rn, st, ld, cl;
    int         a, d;
    logic       ev;
    logic [7:0] ed;
    logic       eb;
  } vec_t;

  function automatic vec_t mk(input logic rn, input logic st, input logic ld,
                              input logic cl, input int a, input int d,
                              input logic ev, input logic [7:0] ed, input logic eb);
    vec_t v;
    v.rn = rn; v.st = st; v.ld = ld; v.cl = cl; v.a = a; v.d = d;
    v.ev = ev; v.ed = ed; v.eb = eb;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    int busy_cnt;
    int guard;

    // Directed vectors, expectations for the DEPTH=8 instance after each edge.
    tbl[0]  = mk(0, 0, 0, 0, 0, 8'h00, 0, 8'h00, 0);  // reset
    tbl[1]  = mk(1, 1, 0, 0, 3, 8'hA5, 0, 8'h00, 0);  // write A5@3
    tbl[2]  = mk(1, 1, 0, 0, 7, 8'h3C, 0, 8'h00, 0);  // write 3C@7
    tbl[3]  = mk(1, 0, 1, 0, 3, 8'h00, 1, 8'hA5, 0);  // load@3
    tbl[4]  = mk(1, 0, 1, 0, 7, 8'h00, 1, 8'h3C, 0);  // load@7
    tbl[5]  = mk(1, 0, 0, 0, 0, 8'h00, 0, 8'h3C, 0);  // rd_data holds
    tbl[6]  = mk(1, 1, 1, 0, 2, 8'h5A, 1, 8'h5A, 0);  // write-through
    tbl[7]  = mk(1, 0, 1, 0, 2, 8'h00, 1, 8'h5A, 0);  // back-to-back load
    tbl[8]  = mk(1, 0, 1, 1, 3, 8'h00, 0, 8'h5A, 1);  // clear beats load
    for (int i = 9; i < 16; i++)
      tbl[i] = mk(1, 0, 1, 0, 3, 8'h00, 0, 8'h5A, 1); // loads ignored while busy
    tbl[16] = mk(1, 0, 0, 0, 0, 8'h00, 0, 8'h5A, 0);  // sweep done
    tbl[17] = mk(1, 0, 1, 0, 3, 8'h00, 1, 8'h00, 0);  // cleared word

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].rn, tbl[i].st, tbl[i].ld, tbl[i].cl, tbl[i].a, tbl[i].d);
      chk($sformatf("vec%0d_rd_valid", i), int'(rd_valid8), int'(tbl[i].ev));
      chk($sformatf("vec%0d_rd_data", i),  int'(rd_data8),  int'(tbl[i].ed));
      chk($sformatf("vec%0d_busy", i),     int'(busy8),     int'(tbl[i].eb));
      $display("vec %0d: rd_valid=%0b rd_data=%02h busy=%0b", i, rd_valid8, rd_data8, busy8);
    end

    // Fill with FF, clear while holding store 0x11: busy for 8 cycles, stores ignored.
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, i, 8'hFF);
    cycle(1, 1, 0, 1, 0, 8'h11);
    busy_cnt = 0;
    guard = 0;
    while (busy8 && guard < 20) begin
      busy_cnt++;
      guard++;
      cycle(1, 1, 0, 0, guard % 8, 8'h11);
    end
    chk("clear_busy_cycles", busy_cnt, 8);
    $display("clear sweep: busy cycles=%0d", busy_cnt);
    for (int i = 0; i < 8; i++) begin
      cycle(1, 0, 1, 0, i, 0);
      chk($sformatf("after_clear_word%0d", i), int'(rd_data8), 0);
      chk($sformatf("after_clear_valid%0d", i), int'(rd_valid8), 1);
      $display("post-clear load@%0d: rd_data=%02h", i, rd_data8);
    end

    // DEPTH=5: out-of-range write/read leaves words 0..4 intact.
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, i, 8'h10 + i);
    cycle(1, 1, 0, 0, 6, 8'h77);
    cycle(1, 0, 1, 0, 6, 0);
    chk("oor_rd_data5", int'(rd_data5), 0);
    chk("oor_rd_valid5", int'(rd_valid5), 1);
    $display("depth5 load@6: rd_data=%02h rd_valid=%0b", rd_data5, rd_valid5);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 1, 0, i, 0);
      chk($sformatf("d5_word%0d", i), int'(rd_data5), 8'h10 + i);
      $display("depth5 load@%0d: rd_data=%02h", i, rd_data5);
    end

    // Reset during the sweep aborts it and leaves everything zero.
    cycle(1, 1, 0, 0, 1, 8'h99);
    cycle(1, 0, 1, 0, 1, 0);
    chk("pre_abort_word1", int'(rd_data8), 8'h99);
    cycle(1, 0, 0, 1, 0, 0);   // busy cycle 1 follows
    cycle(1, 0, 0, 0, 0, 0);   // busy cycle 2 follows
    cycle(1, 0, 0, 0, 0, 0);   // busy cycle 3 follows
    chk("abort_busy_before", int'(busy8), 1);
    cycle(0, 1, 1, 1, 1, 8'h55);
    chk("abort_busy", int'(busy8), 0);
    chk("abort_rd_valid", int'(rd_valid8), 0);
    chk("abort_rd_data", int'(rd_data8), 0);
    cycle(1, 0, 1, 0, 1, 0);
    chk("abort_word1", int'(rd_data8), 0);
    chk("abort_word1_valid", int'(rd_valid8), 1);
    $display("after abort load@1: rd_data=%02h", rd_data8);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic rn, st, ld, cl;
      rn = ($urandom_range(99) >= 2);
      cl = ($urandom_range(99) < 3);
      st = ($urandom_range(99) < 45);
      ld = ($urandom_range(99) < 45);
      cycle(rn, st, ld, cl, $urandom_range(7), $urandom_range(255));
      $display("rand %0d: rn=%0b st=%0b ld=%0b cl=%0b a=%0d -> v8=%0b d8=%02h b8=%0b v5=%0b d5=%02h b5=%0b",
               i, rn, st, ld, cl, addr, rd_valid8, rd_data8, busy8, rd_valid5, rd_data5, busy5);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
